// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Signal bundle between a UART receiver and its consumer.
//                master = receiver side (line and pop strobe in, byte and
//                status flags out); slave = the consumer side.
//  Signals     : in        - asynchronous UART line, idle high
//                read      - pop strobe
//                err_clr   - clears the sticky error flags
//                data      - FIFO head byte (valid only while valid=1)
//                valid     - FIFO not empty
//                frame_err - sticky: stop bit sampled low
//                overrun   - sticky: byte dropped because the FIFO was full
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
   logic       in;
   logic       read;
   logic       err_clr;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   modport master (
      input  in, read, err_clr,
      output data, valid, frame_err, overrun
   );

   modport slave (
      output in, read, err_clr,
      input  data, valid, frame_err, overrun
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Buffered 8n1 UART receiver, LSB first. The line is passed
//                through a 2-FF synchroniser, the frame is sampled at
//                mid-bit using an OVERSAMPLE-tick counter, and good bytes are
//                queued in a DEPTH-entry first-word-fall-through FIFO.
//  Parameters  : OVERSAMPLE - clk cycles per bit (even, >= 4)
//                DEPTH      - FIFO entries (power of 2, >= 2)
//  Ports       : clk - receiver clock (OVERSAMPLE x baud)
//                rst - synchronous active-high reset
//                bus - uart_rx_if.master (line, pop, error clear, byte, flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DEPTH      = 16
) (
   input  logic       clk,
   input  logic       rst,
   uart_rx_if.master  bus
);

   localparam int c_TW = $clog2(OVERSAMPLE);
   localparam int c_PW = $clog2(DEPTH);

   localparam logic [c_TW-1:0] c_tick_half = c_TW'(OVERSAMPLE/2 - 1);
   localparam logic [c_TW-1:0] c_tick_full = c_TW'(OVERSAMPLE - 1);
   localparam logic [c_PW:0]   c_depth_cnt = (c_PW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // ---------------------------------------------------------------- receiver
   logic            r_sync1;
   logic            r_sync2;
   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_TW-1:0] r_tick;
   logic [c_TW-1:0] w_tick_nxt;
   logic [2:0]      r_bit;
   logic [2:0]      w_bit_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic            w_push;
   logic            w_frame_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= S_IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_sync1 <= bus.in;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_frame_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tick_nxt = '0;
            if (!r_sync2) w_state_nxt = S_START;
         end
         S_START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (r_tick == c_tick_half) begin
               w_tick_nxt = '0;
               w_bit_nxt  = '0;
               w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
            end else begin
               w_tick_nxt = r_tick + 1'b1;
            end
         end
         S_DATA: begin
            if (r_tick == c_tick_full) begin
               w_tick_nxt = '0;
               // Shift right so the first (LSB) bit ends up in bit 0.
               w_shift_nxt = {r_sync2, r_shift[7:1]};
               if (r_bit == 3'd7) w_state_nxt = S_STOP;
               else               w_bit_nxt   = r_bit + 1'b1;
            end else begin
               w_tick_nxt = r_tick + 1'b1;
            end
         end
         S_STOP: begin
            if (r_tick == c_tick_full) begin
               w_tick_nxt = '0;
               if (r_sync2) begin
                  w_push      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_frame_set = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end else begin
               w_tick_nxt = r_tick + 1'b1;
            end
         end
         S_BREAK: begin
            // Hold here until the line is released so a stuck-low line
            // cannot produce a stream of bogus frames.
            w_tick_nxt = '0;
            if (r_sync2) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------- FIFO
   logic [7:0]      r_mem [DEPTH];
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_PW-1:0] r_rd_ptr;
   logic [c_PW:0]   r_count;
   logic            r_frame_err;
   logic            r_overrun;
   logic            w_valid;
   logic            w_full;
   logic            w_pop;
   logic            w_push_ok;
   logic            w_overrun_set;

   assign w_valid       = (r_count != '0);
   assign w_full        = (r_count == c_depth_cnt);
   assign w_pop         = bus.read & w_valid;
   // A pop in the same cycle frees the slot being written when full.
   assign w_push_ok     = w_push & (~w_full | w_pop);
   assign w_overrun_set = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
         // Set has priority over clear.
         r_frame_err <= w_frame_set   | (r_frame_err & ~bus.err_clr);
         r_overrun   <= w_overrun_set | (r_overrun   & ~bus.err_clr);
      end
   end

   assign bus.data      = r_mem[r_rd_ptr];
   assign bus.valid     = w_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx (OVERSAMPLE=16, DEPTH=4).
//                Frames are driven bit by bit at negedges; outputs are sampled
//                at negedges. A queue-based model tracks expected FIFO
//                contents and sticky flags for the randomized scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
   localparam int OS  = 16;
   localparam int DEP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(.OVERSAMPLE(OS), .DEPTH(DEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int lat    = 155;   // push-visible cycle, refined by the single-byte test

   logic [7:0] model_q[$];
   logic       model_ov;
   logic       model_fe;

   // Drive one 10-bit frame (start, 8 data LSB first, stop). read is pulsed
   // in the cycle after negedge number read_at; rise returns the first
   // negedge index (1-based) at which valid was seen high.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int read_at, output int rise);
      logic [9:0] f;
      int k;
      f = {stop_bit, b, 1'b0};
      rise = -1;
      for (int i = 0; i < 10; i++) begin
         bus.in = f[i];
         for (int t = 0; t < OS; t++) begin
            @(negedge clk);
            k = i*OS + t + 1;
            bus.read = (k == read_at);
            if (rise < 0 && bus.valid === 1'b1) rise = k;
         end
      end
      bus.in   = 1'b1;
      bus.read = 1'b0;
   endtask

   task automatic do_read(output logic [7:0] d);
      d = bus.data;
      bus.read = 1'b1;
      @(negedge clk);
      bus.read = 1'b0;
   endtask

   task automatic do_clr();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
   endtask

   task automatic chk_head(input string name, input logic [7:0] exp);
      checks++;
      if (bus.valid !== 1'b1 || bus.data !== exp) begin
         errors++;
         $display("FAIL %s: valid=%b data=%h, expected valid=1 data=%h",
                  name, bus.valid, bus.data, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.in = 1'b1; bus.read = 1'b0; bus.err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.valid, bus.frame_err, bus.overrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: valid/frame_err/overrun=%b%b%b expected 000",
                     i, bus.valid, bus.frame_err, bus.overrun);
         end
      end
   endtask

   task automatic test_single_byte();
      int r; logic [7:0] d;
      send_frame(8'hA5, 1'b1, -1, r);
      checks++;
      if (r < 153 || r > 156) begin
         errors++;
         $display("FAIL single_latency: valid rose at %0d, expected 153..156", r);
      end else lat = r;
      chk_head("single_data", 8'hA5);
      do_read(d);
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: valid=%b expected 0", bus.valid);
      end
   endtask

   task automatic test_glitch();
      int r; logic [7:0] d;
      bus.in = 1'b0;
      repeat (4) @(negedge clk);
      bus.in = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL glitch_reject: valid=%b frame_err=%b expected 0 0",
                  bus.valid, bus.frame_err);
      end
      send_frame(8'h3C, 1'b1, -1, r);
      repeat (2) @(negedge clk);
      chk_head("glitch_next_frame", 8'h3C);
      do_read(d);
   endtask

   task automatic test_framing();
      int r; logic [7:0] d;
      send_frame(8'h55, 1'b0, -1, r);
      bus.in = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (bus.frame_err !== 1'b1 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL framing_err: frame_err=%b valid=%b expected 1 0",
                  bus.frame_err, bus.valid);
      end
      bus.in = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL break_no_frame: valid=%b expected 0", bus.valid);
      end
      send_frame(8'h12, 1'b1, -1, r);
      repeat (2) @(negedge clk);
      chk_head("after_break", 8'h12);
      do_read(d);
      do_clr();
      checks++;
      if (bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_clear: frame_err=%b expected 0", bus.frame_err);
      end
   endtask

   task automatic test_overrun();
      int r; logic [7:0] d;
      for (int b = 1; b <= 5; b++) begin
         send_frame(8'(b), 1'b1, -1, r);
         if (b == 4) begin
            checks++;
            if (bus.overrun !== 1'b0) begin
               errors++;
               $display("FAIL overrun_early: overrun=%b expected 0", bus.overrun);
            end
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: overrun=%b expected 1", bus.overrun);
      end
      for (int j = 1; j <= 4; j++) begin
         chk_head("overrun_contents", 8'(j));
         do_read(d);
      end
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_drain: valid=%b expected 0", bus.valid);
      end
      do_clr();
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: overrun=%b expected 0", bus.overrun);
      end
   endtask

   task automatic test_back_to_back_full_pop();
      int r; logic [7:0] d;
      for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, -1, r);
      // read lands on the same posedge as the push of the fifth byte
      send_frame(8'h05, 1'b1, lat - 1, r);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL simul_overrun: overrun=%b expected 0", bus.overrun);
      end
      for (int j = 2; j <= 5; j++) begin
         chk_head("simul_contents", 8'(j));
         do_read(d);
      end
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_drain: valid=%b expected 0", bus.valid);
      end
   endtask

   task automatic test_reset_midframe();
      int r;
      send_frame(8'h77, 1'b1, -1, r);
      bus.in = 1'b0;
      repeat (3*OS) @(negedge clk);
      rst = 1'b1; bus.in = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset: valid=%b frame_err=%b expected 0 0",
                  bus.valid, bus.frame_err);
      end
      repeat (200) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL midframe_partial: valid=%b frame_err=%b expected 0 0",
                  bus.valid, bus.frame_err);
      end
   endtask

   task automatic test_random();
      int r, nrd; logic [7:0] b, d; logic good;
      model_q.delete(); model_ov = 1'b0; model_fe = 1'b0;
      for (int n = 0; n < 20; n++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 4) != 0);
         send_frame(b, good, -1, r);
         if (!good)                  model_fe = 1'b1;
         else if (model_q.size() < DEP) model_q.push_back(b);
         else                        model_ov = 1'b1;
         repeat (4) @(negedge clk);
         checks++;
         if (bus.frame_err !== model_fe || bus.overrun !== model_ov) begin
            errors++;
            $display("FAIL rand_flags frame %0d: frame_err=%b overrun=%b expected %b %b",
                     n, bus.frame_err, bus.overrun, model_fe, model_ov);
         end
         nrd = $urandom_range(0, 3);
         for (int j = 0; j < nrd; j++) begin
            if (model_q.size() > 0) begin
               chk_head("rand_data", model_q[0]);
               void'(model_q.pop_front());
            end else begin
               checks++;
               if (bus.valid !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_empty: valid=%b expected 0", bus.valid);
               end
            end
            do_read(d);
         end
         if ($urandom_range(0, 1) == 1) begin
            do_clr();
            model_fe = 1'b0; model_ov = 1'b0;
         end
      end
   endtask

   initial begin
      bus.in = 1'b1; bus.read = 1'b0; bus.err_clr = 1'b0;
      test_reset();
      test_single_byte();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back_full_pop();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d",
               errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Buffered UART receiver, 8n1 format, LSB first.
- Counterpart of the team's buffered transmitter; sits directly downstream of a physical RX pin.
- Oversamples the line, validates start and stop bits, and queues received bytes in an internal FIFO.
- Consumers read bytes through a first-word-fall-through valid/read handshake.

Parameters:
OVERSAMPLE, 16, clk cycles per bit; even, >= 4.
DEPTH, 16, FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  receiver clock, OVERSAMPLE x baud (e.g. 1.8432 MHz for 115200).
rst  input  1  synchronous active-high reset.
in  input  1  asynchronous UART line, idle high.
read  input  1  pop strobe, sampled at posedge clk.
err_clr  input  1  clears frame_err and overrun.
data  output  8  FIFO head byte; valid only while valid=1.
valid  output  1  FIFO not empty.
frame_err  output  1  sticky: stop bit sampled low.
overrun  output  1  sticky: byte dropped because FIFO full.

Behaviour:
- All state updates on posedge clk.
- Reset (rst=1 at a posedge):
  - synchroniser FFs = 1; FSM = IDLE; bit/tick counters = 0.
  - FIFO pointers and count = 0.
  - valid = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- Input: 2-FF synchroniser; FSM uses only the second FF (rx_s). Input-to-FSM latency is 2 clk.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: if rx_s=0, go to START with tick=0.
  - START: tick counts to OVERSAMPLE/2-1. At that tick, sample rx_s:
    - 1: false start, go to IDLE.
    - 0: go to DATA with tick=0, bit=0.
  - DATA: each time tick reaches OVERSAMPLE-1, sample rx_s into shift[bit], LSB first, and reset tick. After bit 7 is sampled, go to STOP.
  - STOP: at tick OVERSAMPLE-1, sample rx_s:
    - 1: push shift into the FIFO, go to IDLE.
    - 0: set frame_err, drop the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Timing: stop-bit sample occurs 2 + OVERSAMPLE/2 + 9*OVERSAMPLE - 1 clk after the falling edge on in (tolerance ±1). The push is visible (valid=1, data=byte) on the next clk. For OVERSAMPLE=16 that is ~154 clk.
- Back-to-back frames: a new start bit is accepted on the cycle after returning to IDLE. No idle gap is required beyond the stop bit.
- FIFO: DEPTH entries; ptr width log2(DEPTH), count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
  - pop = read & valid. read while valid=0 is ignored; no underflow.
  - push is accepted if count < DEPTH, or if pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged and data remains ordered.
  - push while full with no pop: byte dropped, overrun set, FIFO contents unchanged.
  - data is combinational from mem[rd_ptr], first-word-fall-through. valid = (count != 0).
- Sticky flags: set and clear are both registered.
  - err_clr=1 clears frame_err and overrun.
  - If err_clr and a set condition occur in the same cycle, the flag ends set (set wins).
- No parity support. No baud detection.

Test Plan:
- Reset/idle: rst high 3 clk with in=1, then 200 clk idle -> valid=0, frame_err=0, overrun=0 throughout.
- Single byte: send 0xA5 at OVERSAMPLE=16 -> valid rises 154±1 clk after start edge with data=0xA5; pulse read -> valid=0 next clk.
- Glitch rejection: in low for 4 clk, then high -> FSM back to IDLE, valid stays 0. A following 0x3C frame is received correctly.
- Framing/break: send 0x55 with stop bit low, hold in low 40 clk -> frame_err=1, no push, no second frame. Release line, send 0x12 -> data=0x12. err_clr -> frame_err=0.
- Full/overrun with DEPTH=4, no reads:
  - Send 0x01..0x05 -> bytes 0x01..0x04 stored, overrun=1 after 5th stop bit.
  - Reading 4 times yields 0x01,0x02,0x03,0x04, then valid=0.
- Simultaneous push/pop at full, DEPTH=4: assert read on the push cycle of a 5th byte -> overrun stays 0; subsequent reads return 0x02,0x03,0x04,0x05. Also assert rst mid-frame -> valid=0 and the partial byte is never delivered.
